countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Seconds countdown timer; the design-side end of the start/counterSeconds interface that our counter benches drive.
- Latches a 10-bit seconds value on a start edge and decrements it once per CLKS_PER_SEC clock cycles.
- Pulses done when the count reaches zero.
- Used by the lab-2 control logic for timed phases, e.g. fill and drain intervals.

Parameters:
- CLKS_PER_SEC, 50000000, clock cycles per one-second tick; legal range 1 to 2^26; benches use 1 or 4.
- WIDTH, 10, width of the seconds value and of the remaining count.

Ports:
- Clock  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- start  input  1  request to load and run; acted on only on a 0-to-1 transition.
- counterSeconds  input  WIDTH  seconds to count; sampled only on a start edge.
- remaining  output  WIDTH  seconds left (registered).
- busy  output  1  high while counting.
- tick  output  1  one-cycle pulse on every decrement.
- done  output  1  one-cycle pulse when the count expires.

Behaviour:
- Reset:
  - Clock is the single clock.
  - Reset is asynchronous and active-low.
  - Reset low immediately forces: state IDLE, remaining=0, busy=0, tick=0, done=0, prescaler=0, start_q=0, reload register=0.
  - Reset low mid-count aborts the count with no done pulse.
- Start edge detect:
  - start_q registers start every cycle.
  - start_edge = start & ~start_q.
  - Holding start high produces exactly one start edge.
- States:
  - IDLE: busy=0; waits for start_edge.
  - RUN: busy=1; counting.
- On start_edge, in any state:
  - Latch counterSeconds into remaining and the reload register; clear the prescaler.
  - If counterSeconds != 0: go to RUN (busy=1 from the next cycle).
  - If counterSeconds == 0: stay in IDLE and assert done for the single following cycle; tick stays 0.
- In RUN, each cycle without start_edge:
  - If prescaler == CLKS_PER_SEC-1: prescaler <= 0, remaining <= remaining-1, tick=1 for that cycle.
  - Otherwise: prescaler <= prescaler+1.
- Expiry: when a decrement takes remaining from 1 to 0, on the same edge:
  - done=1 for exactly one cycle;
  - busy <= 0;
  - state <= IDLE.
- Latency: start edge sampled at edge k, value S>0 gives:
  - remaining=S after edge k;
  - ticks after edges k+N, k+2N, ..., with N=CLKS_PER_SEC;
  - done and busy=0 after edge k+S*N.
- Restart: a start_edge while in RUN reloads from counterSeconds and clears the prescaler; no done pulse for the aborted count.
- Simultaneous start_edge and final decrement: start wins. The reload happens, no done or tick that cycle, and the state follows the new value.
- Arithmetic:
  - remaining is never decremented below 0.
  - No wrap-around is possible; a decrement occurs only in RUN with remaining >= 1.
  - Prescaler width is clog2(CLKS_PER_SEC), minimum 1 bit.
  - With CLKS_PER_SEC=1 the prescaler is constant 0 and a decrement occurs every RUN cycle.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro COUNTDOWN_AUTORELOAD_EN.
- Defined: on expiry, done still pulses for one cycle, but the timer does not return to IDLE.
  - remaining is loaded from the reload register on the same edge (it does not show 0).
  - The prescaler clears and busy stays 1, giving a periodic done every S*N cycles until reset or a new start_edge.
  - A start edge with counterSeconds == 0 still behaves as one-shot (done once, stay IDLE).
- Not defined: one-shot behaviour as specified above. The reload register is only needed for this feature and is optimised away when the macro is not defined.

Test Plan:
- CLKS_PER_SEC=1; Reset low 2 cycles then high; counterSeconds=7; start high 1 cycle.
  -> remaining 7,6,...,1 on successive edges; tick each cycle; done=1 and busy=0 exactly 7 edges after the start edge; remaining=0 thereafter.
- CLKS_PER_SEC=4, counterSeconds=3, start held high 20 cycles.
  -> one load only; tick every 4 cycles; done at start edge+12; no re-trigger while start stays high.
- CLKS_PER_SEC=1, counterSeconds=0, start pulse.
  -> busy never asserts; done=1 for exactly the cycle after the start edge; tick never asserts.
- CLKS_PER_SEC=1, counterSeconds=5, start.
  -> after remaining reaches 2, drive counterSeconds=9 and pulse start; remaining=9 next edge, no done for the first run, done 9 edges after the restart.
- CLKS_PER_SEC=4, counterSeconds=6, start; drive Reset low asynchronously (between clock edges) mid-count.
  -> remaining=0, busy=0, done=0 immediately, with no clock edge needed; no done after Reset returns high.
- With COUNTDOWN_AUTORELOAD_EN, CLKS_PER_SEC=1, counterSeconds=3, start.
  -> done pulses every 3 cycles; remaining sequence 3,2,1,3,2,1,...; busy stays 1.

Source files
------------

// File: rtl/countdown_timer.sv
// Seconds countdown: remaining=S one cycle after a start edge, done S*CLKS_PER_SEC cycles later; no backpressure.
// Optional COUNTDOWN_AUTORELOAD_EN: on expiry reload the latched value and keep running (periodic done).
module countdown_timer #(
  parameter int CLKS_PER_SEC = 50000000,
  parameter int WIDTH        = 10
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] counterSeconds,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_SEC - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [PW-1:0]    prescaler, prescaler_n;
  logic [WIDTH-1:0] remaining_n;
  logic             busy_n, tick_n, done_n;
  logic             start_q;
  logic             start_edge;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] reload, reload_n;
`endif

  assign start_edge = start & ~start_q;

  always_comb begin
    state_n     = state;
    prescaler_n = prescaler;
    remaining_n = remaining;
    tick_n      = 1'b0;
    done_n      = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    reload_n    = reload;
`endif

    if (start_edge) begin
      // A start edge always wins, even over a final decrement in the same cycle.
      remaining_n = counterSeconds;
      prescaler_n = '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      reload_n    = counterSeconds;
`endif
      if (counterSeconds != '0) begin
        state_n = RUN;
      end else begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end else if (state == RUN) begin
      if (prescaler == PRE_LAST) begin
        prescaler_n = '0;
        tick_n      = 1'b1;
        if (remaining == WIDTH'(1)) begin
          done_n = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
          remaining_n = reload;
          state_n     = RUN;
`else
          remaining_n = '0;
          state_n     = IDLE;
`endif
        end else begin
          remaining_n = remaining - WIDTH'(1);
        end
      end else begin
        prescaler_n = prescaler + PW'(1);
      end
    end

    busy_n = (state_n == RUN);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      prescaler <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      tick      <= 1'b0;
      done      <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state     <= state_n;
      prescaler <= prescaler_n;
      remaining <= remaining_n;
      busy      <= busy_n;
      tick      <= tick_n;
      done      <= done_n;
      start_q   <= start;
    end
  end

`ifdef COUNTDOWN_AUTORELOAD_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      reload <= '0;
    end else begin
      reload <= reload_n;
    end
  end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: one instance at 1 clk/s, one at 4 clk/s.
module tb_countdown_timer;

  typedef struct {
    int cyc;
    int rem;
    int busy;
    int tick;
    int done;
  } exp_t;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic       rst1_n = 1'b0, start1 = 1'b0;
  logic [9:0] cs1 = '0;
  logic [9:0] rem1;
  logic       busy1, tick1, done1;

  logic       rst4_n = 1'b0, start4 = 1'b0;
  logic [9:0] cs4 = '0;
  logic [9:0] rem4;
  logic       busy4, tick4, done4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q1[$];
  exp_t q4[$];

  countdown_timer #(.CLKS_PER_SEC(1), .WIDTH(10)) dut1 (
    .Clock(Clock), .Reset(rst1_n), .start(start1), .counterSeconds(cs1),
    .remaining(rem1), .busy(busy1), .tick(tick1), .done(done1)
  );

  countdown_timer #(.CLKS_PER_SEC(4), .WIDTH(10)) dut4 (
    .Clock(Clock), .Reset(rst4_n), .start(start4), .counterSeconds(cs4),
    .remaining(rem4), .busy(busy4), .tick(tick4), .done(done4)
  );

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic push_exp(input int which, input int c, input int rem, input int busy,
                          input int tick, input int done);
    exp_t e;
    e.cyc = c; e.rem = rem; e.busy = busy; e.tick = tick; e.done = done;
    if (which == 1) q1.push_back(e);
    else q4.push_back(e);
  endtask

  // Expected outputs for len cycles after a start edge sampled at cycle k.
  task automatic push_run(input int which, input int s, input int k, input int len);
    int n, p, ph;
    n = (which == 1) ? 1 : 4;
    p = s * n;
    for (int j = 0; j < len; j++) begin
      if (s == 0) begin
        push_exp(which, k + j, 0, 0, 0, (j == 0) ? 1 : 0);
      end else begin
`ifdef COUNTDOWN_AUTORELOAD_EN
        ph = j % p;
        push_exp(which, k + j, s - ph / n, 1,
                 (j > 0 && j % n == 0) ? 1 : 0, (j > 0 && ph == 0) ? 1 : 0);
`else
        ph = j;
        if (ph >= p)
          push_exp(which, k + j, 0, 0, (ph == p) ? 1 : 0, (ph == p) ? 1 : 0);
        else
          push_exp(which, k + j, s - ph / n, 1, (ph > 0 && ph % n == 0) ? 1 : 0, 0);
`endif
      end
    end
  endtask

  // Call just after a rising edge; returns with start low, k = cycle of the start edge.
  task automatic drive_start(input int which, input int s, input int hold, input int len,
                             output int k);
    k = cyc + 1;
    if (which == 1) begin cs1 = 10'(s); start1 = 1'b1; end
    else begin cs4 = 10'(s); start4 = 1'b1; end
    push_run(which, s, k, len);
    repeat (hold) begin @(posedge Clock); #1; end
    if (which == 1) start1 = 1'b0;
    else start4 = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  always @(negedge Clock) begin
    exp_t e;
    while (q1.size() > 0 && q1[0].cyc == cyc) begin
      e = q1.pop_front();
      chk("d1_rem", int'(rem1), e.rem);
      chk("d1_busy", int'(busy1), e.busy);
      chk("d1_tick", int'(tick1), e.tick);
      chk("d1_done", int'(done1), e.done);
    end
    while (q4.size() > 0 && q4[0].cyc == cyc) begin
      e = q4.pop_front();
      chk("d4_rem", int'(rem4), e.rem);
      chk("d4_busy", int'(busy4), e.busy);
      chk("d4_tick", int'(tick4), e.tick);
      chk("d4_done", int'(done4), e.done);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2;
    cycles(2);
    chk("rst_rem", int'(rem1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_tick", int'(tick4), 0);
    chk("rst_done", int'(done4), 0);
    rst1_n = 1'b1;
    rst4_n = 1'b1;
    cycles(2);

    // 7 seconds at 1 clk/s
    drive_start(1, 7, 1, 10, k);
    cycles(10);

    // start held high: one load only
    drive_start(4, 3, 20, 22, k);
    cycles(4);

    // zero seconds: done once, never busy
    drive_start(1, 0, 1, 4, k);
    cycles(4);

    // restart while running, when remaining reaches 2
    drive_start(1, 5, 1, 4, k);
    cycles(3);
    drive_start(1, 9, 1, 12, k2);
    cycles(12);

    // async reset mid-count
    drive_start(4, 6, 1, 9, k);
    cycles(8);
    @(negedge Clock);
    #2;
    rst4_n = 1'b0;
    #1;
    chk("arst_rem", int'(rem4), 0);
    chk("arst_busy", int'(busy4), 0);
    chk("arst_done", int'(done4), 0);
    chk("arst_tick", int'(tick4), 0);
    cycles(2);
    #2;
    rst4_n = 1'b1;
    for (int j = 1; j <= 30; j++) push_exp(4, cyc + j, 0, 0, 0, 0);
    cycles(31);

    // periodic done with autoreload, single expiry otherwise
    drive_start(1, 3, 1, 12, k);
    cycles(14);

    chk("q1_leftover", q1.size(), 0);
    chk("q4_leftover", q4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
